jtag_dp_ctrl: RTL and testbench
===============================

# jtag_dp_ctrl

JTAG TAP controller that configures and observes the 8-bit datapath in the project top level. A host loads operand A and operand B through JTAG data registers. The block drives them onto the datapath's `a`/`b` inputs and captures the datapath result `Y` back for readout. The block sits between the top-level pins and the datapath instance and runs entirely in the system clock domain, oversampling TCK.

## Interface

Parameters:
- `DW`, 8: operand/result width.
- `IDCODE_VAL`, 32'h1000_0001: IDCODE register value; bit 0 must be 1.

Ports:
- `clk`  in  1  system clock; all flops on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tck`  in  1  JTAG clock, asynchronous to `clk`; frequency ≤ `clk`/4.
- `tms`  in  1  JTAG mode select.
- `tdi`  in  1  JTAG data in.
- `tdo`  out  1  JTAG data out.
- `tdo_oe`  out  1  high while in Shift-DR or Shift-IR.
- `op_a`  out  DW  operand A to the datapath.
- `op_b`  out  DW  operand B to the datapath.
- `y_in`  in  DW  datapath result.
- `upd_strobe`  out  1  one-`clk` pulse when `op_a` or `op_b` is written.
- `tap_state`  out  4  current TAP state, for debug.

## Operation

- **Pin synchronisation**
  - `tck`, `tms` and `tdi` each pass through a 2-flop synchroniser; sync flops reset to 0.
  - An edge register on synced `tck` produces single-cycle `rise` and `fall` events.
- **TAP state machine**
  - Standard IEEE 1149.1 16-state FSM: TLR, RTI, Sel-DR, Cap-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Upd-DR, plus the IR equivalents.
  - It advances only on `rise`, using synced `tms`.
  - `tap_state` encoding: TLR=0xF, RTI=0xC, Sel-DR=0x7, Cap-DR=0x6, Shift-DR=0x2, Exit1-DR=0x1, Pause-DR=0x3, Exit2-DR=0x0, Upd-DR=0x5, Sel-IR=0x4, Cap-IR=0xE, Shift-IR=0xA, Exit1-IR=0x9, Pause-IR=0xB, Exit2-IR=0x8, Upd-IR=0xD.
  - Five `rise` events with `tms`=1 reach TLR from any state.
- **Instruction register (4 bits)**
  - Opcodes: IDCODE=4'b0001, SEL_A=4'b0010, SEL_B=4'b0011, RESULT=4'b0100, BYPASS=4'b1111. Any other opcode selects BYPASS.
  - Capture-IR loads 4'b0101.
  - The IR shift register shifts LSB-first, with `tdi` entering the MSB.
  - The active IR is loaded on `fall` while in Upd-IR.
  - Entering TLR forces the active IR to IDCODE.
- **Data registers**
  - All shift LSB-first, with `tdi` entering the MSB.
  - IDCODE: 32 bits; captures `IDCODE_VAL`.
  - SEL_A: DW bits; captures the current `op_a`.
  - SEL_B: DW bits; captures the current `op_b`.
  - RESULT: DW bits; captures `y_in`.
  - BYPASS: 1 bit; captures 0.
- **Shift timing**
  - Capture happens on `rise` while in Cap-xR.
  - Shift happens on `rise` while in Shift-xR.
- **Update**
  - On `fall` while in Upd-DR: SEL_A loads `op_a`, SEL_B loads `op_b`, and `upd_strobe` pulses.
  - RESULT, IDCODE and BYPASS update nothing.
- **TDO**
  - On `fall`, `tdo` ← LSB of the selected shift register (IR in IR states, DR otherwise).
  - On the same `fall`, `tdo_oe` ← (state is Shift-DR or Shift-IR).
- **Persistence**
  - `op_a`/`op_b` are cleared only by `rst_n`; TLR does not clear them.

## Timing

- **Reset values**
  - State TLR; active IR = IDCODE.
  - `op_a`=0, `op_b`=0.
  - `tdo`=0, `tdo_oe`=0, `upd_strobe`=0.
  - `tap_state`=0xF.
  - All shift registers 0.
- **Latency**
  - A `tck` pin edge produces its `rise`/`fall` event 3 `clk` cycles later.
  - FSM, shift and update registers change on the `clk` edge after the event.
  - `op_a`/`op_b` change 4 `clk` cycles after the falling `tck` pin edge in Upd-DR.
  - `upd_strobe` is high for exactly 1 `clk` cycle, in the same cycle `op_a`/`op_b` change.
- **TCK limits**
  - `tck` high and low times must each be ≥ 2 `clk` periods.
  - Shorter pulses may be missed; no other behaviour is guaranteed for them.
- **`rst_n` assertion mid-operation**
  - All outputs return to reset values immediately (asynchronously).
  - A shift in progress is discarded.
- **IR change mid-operation**
  - The IR changes only in Upd-IR, so the DR selection is stable throughout any DR scan.

## Configuration

- `JTAG_IDCODE_EN` defined:
  - IDCODE instruction and the 32-bit IDCODE register are present.
  - Reset/TLR loads IR = IDCODE.
- `JTAG_IDCODE_EN` undefined:
  - The IDCODE register is not built, and opcode 4'b0001 selects BYPASS.
  - Reset/TLR loads IR = BYPASS.
  - After reset, the first Shift-DR returns a 0 followed by delayed `tdi`.

## Test plan

- **IDCODE readout** (`JTAG_IDCODE_EN`): release `rst_n`, TMS 0,1,0,0, then 32 Shift-DR clocks → `tdo` serial stream equals 32'h1000_0001 LSB-first; `tdo_oe`=1 only during the shift.
- **IR capture**: enter Shift-IR and shift in 4'b0010 → first 4 `tdo` bits are 1,0,1,0 (4'b0101 LSB-first).
- **Operand load**:
  - Load SEL_A, shift 8'hA5, pass Upd-DR → `op_a`=8'hA5, exactly one `upd_strobe` pulse, `op_b`=0.
  - Repeat with SEL_B and 8'h3C → `op_b`=8'h3C, `op_a` unchanged.
- **Result capture**: with `y_in`=8'h24, select RESULT and scan 8 bits → `tdo` shows 8'h24 LSB-first; `op_a`/`op_b` unchanged.
- **Bypass**: IR=4'b1111 (then opcode 4'b0111) and shift `tdi` 1,0,1,1 → `tdo` reproduces the pattern one TCK late, with a leading 0.
- **Reset paths**:
  - TMS=1 for 5 TCKs from Shift-DR → `tap_state`=0xF, IR=IDCODE, `op_a` retained.
  - `rst_n` low mid Shift-DR → `op_a`=`op_b`=0, `tdo_oe`=0, `tap_state`=0xF in the same cycle.

Source files
------------

// File: rtl/jtag_dp_ctrl.sv
// jtag_dp_ctrl -- JTAG TAP that loads the datapath operands and reads back its result.
// TCK/TMS/TDI are oversampled in the clk domain, so every flop here runs on clk.
// Optional feature macro JTAG_IDCODE_EN: builds the 32-bit IDCODE data register and
// makes IDCODE the reset instruction (needs DW <= 32); otherwise reset selects BYPASS.
module jtag_dp_ctrl #(
  parameter int          DW         = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tck,
  input  logic          tms,
  input  logic          tdi,
  output logic          tdo,
  output logic          tdo_oe,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  input  logic [DW-1:0] y_in,
  output logic          upd_strobe,
  output logic [3:0]    tap_state
);

  typedef enum logic [3:0] {
    TLR      = 4'hF, RTI      = 4'hC, SEL_DR   = 4'h7, CAP_DR   = 4'h6,
    SHIFT_DR = 4'h2, EXIT1_DR = 4'h1, PAUSE_DR = 4'h3, EXIT2_DR = 4'h0,
    UPD_DR   = 4'h5, SEL_IR   = 4'h4, CAP_IR   = 4'hE, SHIFT_IR = 4'hA,
    EXIT1_IR = 4'h9, PAUSE_IR = 4'hB, EXIT2_IR = 4'h8, UPD_IR   = 4'hD
  } tap_state_e;

  typedef enum logic [2:0] {
    DR_BYPASS, DR_IDCODE, DR_SEL_A, DR_SEL_B, DR_RESULT
  } dr_sel_e;

  localparam logic [3:0] OP_SEL_A  = 4'b0010;
  localparam logic [3:0] OP_SEL_B  = 4'b0011;
  localparam logic [3:0] OP_RESULT = 4'b0100;
  localparam logic [3:0] OP_BYPASS = 4'b1111;
  localparam logic [3:0] IR_CAP    = 4'b0101;

`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] OP_IDCODE = 4'b0001;
  localparam int         SR_W      = 32;
  localparam logic [3:0] IR_RESET  = OP_IDCODE;
`else
  localparam int         SR_W      = DW;
  localparam logic [3:0] IR_RESET  = OP_BYPASS;
`endif

  logic [1:0]    tck_sync, tms_sync, tdi_sync;
  logic          tck_d, rise, fall, tms_q, tdi_q;
  tap_state_e    state, state_next;
  logic          shifting, ir_path;
  logic [3:0]    ir_shift, ir_active;
  logic [SR_W-1:0] dr_shift;
  dr_sel_e       dr_sel;

  // Two-flop synchronisers plus a registered edge detector on synced TCK;
  // TMS/TDI get one extra stage so they line up with the rise/fall events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_d    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      tms_q    <= 1'b0;
      tdi_q    <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[0], tck};
      tms_sync <= {tms_sync[0], tms};
      tdi_sync <= {tdi_sync[0], tdi};
      tck_d    <= tck_sync[1];
      rise     <= tck_sync[1] & ~tck_d;
      fall     <= ~tck_sync[1] & tck_d;
      tms_q    <= tms_sync[1];
      tdi_q    <= tdi_sync[1];
    end
  end

  // TAP state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TLR;
    else        state <= state_next;
  end

  // IEEE 1149.1 transitions, taken only on a TCK rise.
  always_comb begin
    state_next = state;
    if (rise) begin
      case (state)
        TLR:      state_next = tms_q ? TLR      : RTI;
        RTI:      state_next = tms_q ? SEL_DR   : RTI;
        SEL_DR:   state_next = tms_q ? SEL_IR   : CAP_DR;
        CAP_DR:   state_next = tms_q ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state_next = tms_q ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state_next = tms_q ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_next = tms_q ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state_next = tms_q ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state_next = tms_q ? SEL_DR   : RTI;
        SEL_IR:   state_next = tms_q ? TLR      : CAP_IR;
        CAP_IR:   state_next = tms_q ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state_next = tms_q ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state_next = tms_q ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_next = tms_q ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state_next = tms_q ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state_next = tms_q ? SEL_DR   : RTI;
        default:  state_next = TLR;
      endcase
    end
  end

  // State decodes used by the shift and TDO logic.
  always_comb begin
    tap_state = state;
    shifting  = (state == SHIFT_DR) || (state == SHIFT_IR);
    ir_path   = (state == CAP_IR) || (state == SHIFT_IR) || (state == EXIT1_IR) ||
                (state == PAUSE_IR) || (state == EXIT2_IR) || (state == UPD_IR);
  end

  // Active instruction to data-register select; unknown opcodes fall back to BYPASS.
  always_comb begin
    dr_sel = DR_BYPASS;
    case (ir_active)
`ifdef JTAG_IDCODE_EN
      OP_IDCODE: dr_sel = DR_IDCODE;
`endif
      OP_SEL_A:  dr_sel = DR_SEL_A;
      OP_SEL_B:  dr_sel = DR_SEL_B;
      OP_RESULT: dr_sel = DR_RESULT;
      default:   dr_sel = DR_BYPASS;
    endcase
  end

  // Capture and LSB-first shift of the IR and DR shift registers on TCK rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_shift <= '0;
      dr_shift <= '0;
    end else if (rise) begin
      case (state)
        CAP_IR:   ir_shift <= IR_CAP;
        SHIFT_IR: ir_shift <= {tdi_q, ir_shift[3:1]};
        CAP_DR: begin
          case (dr_sel)
            DR_IDCODE: dr_shift <= SR_W'(IDCODE_VAL);
            DR_SEL_A:  dr_shift <= SR_W'(op_a);
            DR_SEL_B:  dr_shift <= SR_W'(op_b);
            DR_RESULT: dr_shift <= SR_W'(y_in);
            default:   dr_shift <= '0;
          endcase
        end
        SHIFT_DR: begin
          case (dr_sel)
`ifdef JTAG_IDCODE_EN
            DR_IDCODE: dr_shift <= {tdi_q, dr_shift[SR_W-1:1]};
`endif
            DR_SEL_A, DR_SEL_B, DR_RESULT: dr_shift[DW-1:0] <= {tdi_q, dr_shift[DW-1:1]};
            default:   dr_shift[0] <= tdi_q;
          endcase
        end
        default: ;
      endcase
    end
  end

  // TCK-fall work: drive TDO/TDO_OE, apply IR and operand updates, pulse the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdo        <= 1'b0;
      tdo_oe     <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      upd_strobe <= 1'b0;
      ir_active  <= IR_RESET;
    end else begin
      upd_strobe <= 1'b0;
      if (state == TLR) begin
        ir_active <= IR_RESET;
      end
      if (fall) begin
        tdo    <= ir_path ? ir_shift[0] : dr_shift[0];
        tdo_oe <= shifting;
        if (state == UPD_IR) begin
          ir_active <= ir_shift;
        end
        if (state == UPD_DR) begin
          if (dr_sel == DR_SEL_A) begin
            op_a       <= dr_shift[DW-1:0];
            upd_strobe <= 1'b1;
          end else if (dr_sel == DR_SEL_B) begin
            op_b       <= dr_shift[DW-1:0];
            upd_strobe <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_dp_ctrl.sv
// tb_jtag_dp_ctrl -- self-checking bench for jtag_dp_ctrl with a transaction-level
// reference model: a DR scan of n bits through a register of length L that captured C
// with serial input D yields the stream {D, C} on TDO, and leaves {D, C} >> n behind.
module tb_jtag_dp_ctrl;

  localparam int          DW  = 8;
  localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0]  IR_RESET_TB = 4'b0001;
`else
  localparam logic [3:0]  IR_RESET_TB = 4'b1111;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tck = 1'b0;
  logic          tms = 1'b0;
  logic          tdi = 1'b0;
  logic          tdo, tdo_oe, upd_strobe;
  logic [DW-1:0] op_a, op_b;
  logic [DW-1:0] y_in = '0;
  logic [3:0]    tap_state;

  int            checks = 0;
  int            errors = 0;
  int            strobe_cnt = 0;
  logic [DW-1:0] exp_a = '0;
  logic [DW-1:0] exp_b = '0;

  jtag_dp_ctrl #(.DW(DW), .IDCODE_VAL(IDV)) dut (
    .clk(clk), .rst_n(rst_n), .tck(tck), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_oe(tdo_oe), .op_a(op_a), .op_b(op_b), .y_in(y_in),
    .upd_strobe(upd_strobe), .tap_state(tap_state)
  );

  // System clock.
  always #5 clk = ~clk;

  // Count strobe pulses, sampled away from the active edge.
  always @(negedge clk) if (upd_strobe === 1'b1) strobe_cnt++;

  // Watchdog so the run always terminates.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full TCK period; returns TDO/TDO_OE as they stand after this period's fall.
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v, output logic oe_v);
    tms = tms_v;
    tdi = tdi_v;
    wait_clk(4);
    tck = 1'b1;
    wait_clk(4);
    tck = 1'b0;
    wait_clk(6);
    tdo_v = tdo;
    oe_v  = tdo_oe;
  endtask

  task automatic tck_step(input logic tms_v);
    logic t, o;
    tck_cycle(tms_v, 1'b0, t, o);
  endtask

  // IR scan from RTI back to RTI; returns the 4 bits seen on TDO.
  task automatic scan_ir(input logic [3:0] op, output logic [3:0] cap);
    logic t, o;
    tck_step(1'b1);
    tck_step(1'b1);
    tck_step(1'b0);
    tck_cycle(1'b0, 1'b0, t, o);
    cap[0] = t;
    for (int k = 0; k < 4; k++) begin
      tck_cycle(k == 3, op[k], t, o);
      if (k < 3) cap[k+1] = t;
    end
    tck_step(1'b1);
    tck_step(1'b0);
  endtask

  // DR scan of n bits from RTI back to RTI; counts TDO_OE values that are wrong.
  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout, output int oe_bad);
    logic t, o;
    dout   = '0;
    oe_bad = 0;
    tck_step(1'b1);
    tck_cycle(1'b0, 1'b0, t, o);
    if (o !== 1'b0) oe_bad++;
    tck_cycle(1'b0, 1'b0, t, o);
    dout[0] = t;
    if (o !== 1'b1) oe_bad++;
    for (int k = 0; k < n; k++) begin
      tck_cycle(k == n - 1, din[k], t, o);
      if (k < n - 1) begin
        dout[k+1] = t;
        if (o !== 1'b1) oe_bad++;
      end else if (o !== 1'b0) begin
        oe_bad++;
      end
    end
    tck_step(1'b1);
    tck_step(1'b0);
  endtask

  function automatic int dr_len(input logic [3:0] op);
    case (op)
`ifdef JTAG_IDCODE_EN
      4'b0001: return 32;
`endif
      4'b0010, 4'b0011, 4'b0100: return DW;
      default: return 1;
    endcase
  endfunction

  function automatic logic [63:0] cap_val(input logic [3:0] op);
    case (op)
`ifdef JTAG_IDCODE_EN
      4'b0001: return {32'd0, IDV};
`endif
      4'b0010: return 64'(exp_a);
      4'b0011: return 64'(exp_b);
      4'b0100: return 64'(y_in);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] stream(input int len, input logic [63:0] cap, input logic [63:0] din);
    return (din << len) | (cap & ((64'd1 << len) - 64'd1));
  endfunction

  function automatic logic [63:0] model_out(input int len, input logic [63:0] cap, input logic [63:0] din, input int n);
    return stream(len, cap, din) & ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] model_left(input int len, input logic [63:0] cap, input logic [63:0] din, input int n);
    return stream(len, cap, din) >> n;
  endfunction

  task automatic test_reset();
    wait_clk(2);
    checks++;
    if (tap_state !== 4'hF) begin errors++; $display("[TB] FAIL reset_state_in_reset: got %h expected %h", tap_state, 4'hF); end
    rst_n = 1'b1;
    wait_clk(3);
    checks++;
    if (tap_state !== 4'hF) begin errors++; $display("[TB] FAIL reset_state: got %h expected %h", tap_state, 4'hF); end
    checks++;
    if (op_a !== '0 || op_b !== '0) begin errors++; $display("[TB] FAIL reset_ops: got %h/%h expected 0/0", op_a, op_b); end
    checks++;
    if (tdo !== 1'b0 || tdo_oe !== 1'b0 || upd_strobe !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_outs: got tdo=%b oe=%b strobe=%b expected 0", tdo, tdo_oe, upd_strobe);
    end
  endtask

  task automatic test_idcode();
    logic [63:0] din, dout, exp;
    int oe_bad;
    tck_step(1'b0);
    checks++;
    if (tap_state !== 4'hC) begin errors++; $display("[TB] FAIL rti_state: got %h expected %h", tap_state, 4'hC); end
    din = {32'd0, $urandom};
    scan_dr(32, din, dout, oe_bad);
    exp = model_out(dr_len(IR_RESET_TB), cap_val(IR_RESET_TB), din, 32);
    checks++;
    if (dout !== exp) begin errors++; $display("[TB] FAIL first_dr_scan: got %h expected %h", dout, exp); end
    checks++;
    if (oe_bad != 0) begin errors++; $display("[TB] FAIL first_dr_oe: got %0d bad expected 0", oe_bad); end
  endtask

  task automatic test_ir_capture();
    logic [3:0] cap;
    scan_ir(4'b0010, cap);
    checks++;
    if (cap !== 4'b0101) begin errors++; $display("[TB] FAIL ir_capture: got %b expected %b", cap, 4'b0101); end
    checks++;
    if (tap_state !== 4'hC) begin errors++; $display("[TB] FAIL ir_end_state: got %h expected %h", tap_state, 4'hC); end
  endtask

  task automatic test_operand_load();
    logic [3:0] cap;
    logic [63:0] dout;
    int oe_bad, s0;
    scan_ir(4'b0010, cap);
    s0 = strobe_cnt;
    scan_dr(DW, 64'hA5, dout, oe_bad);
    checks++;
    if (dout[DW-1:0] !== exp_a) begin errors++; $display("[TB] FAIL sel_a_capture: got %h expected %h", dout[DW-1:0], exp_a); end
    exp_a = 8'hA5;
    checks++;
    if (op_a !== exp_a || op_b !== exp_b) begin errors++; $display("[TB] FAIL sel_a_load: got %h/%h expected %h/%h", op_a, op_b, exp_a, exp_b); end
    checks++;
    if (strobe_cnt - s0 != 1) begin errors++; $display("[TB] FAIL sel_a_strobe: got %0d expected 1", strobe_cnt - s0); end
    scan_ir(4'b0011, cap);
    s0 = strobe_cnt;
    scan_dr(DW, 64'h3C, dout, oe_bad);
    exp_b = 8'h3C;
    checks++;
    if (op_a !== exp_a || op_b !== exp_b) begin errors++; $display("[TB] FAIL sel_b_load: got %h/%h expected %h/%h", op_a, op_b, exp_a, exp_b); end
    checks++;
    if (strobe_cnt - s0 != 1) begin errors++; $display("[TB] FAIL sel_b_strobe: got %0d expected 1", strobe_cnt - s0); end
  endtask

  task automatic test_result();
    logic [3:0] cap;
    logic [63:0] dout;
    int oe_bad, s0;
    scan_ir(4'b0100, cap);
    for (int i = 0; i < 3; i++) begin
      y_in = (i == 0) ? 8'h24 : DW'($urandom);
      s0 = strobe_cnt;
      scan_dr(DW, 64'($urandom), dout, oe_bad);
      checks++;
      if (dout[DW-1:0] !== y_in) begin errors++; $display("[TB] FAIL result_read: got %h expected %h", dout[DW-1:0], y_in); end
      checks++;
      if (op_a !== exp_a || op_b !== exp_b || strobe_cnt != s0) begin
        errors++; $display("[TB] FAIL result_no_update: got %h/%h strobes %0d expected %h/%h strobes 0", op_a, op_b, strobe_cnt - s0, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_bypass();
    logic [3:0] cap;
    logic [63:0] dout, exp, din;
    int oe_bad;
    scan_ir(4'b1111, cap);
    scan_dr(4, 64'hD, dout, oe_bad);
    exp = model_out(1, 64'd0, 64'hD, 4);
    checks++;
    if (dout !== exp) begin errors++; $display("[TB] FAIL bypass_1111: got %h expected %h", dout, exp); end
    scan_ir(4'b0111, cap);
    din = 64'($urandom_range(0, 255));
    scan_dr(8, din, dout, oe_bad);
    exp = model_out(1, 64'd0, din, 8);
    checks++;
    if (dout !== exp) begin errors++; $display("[TB] FAIL bypass_0111: got %h expected %h", dout, exp); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] cap;
    logic [63:0] dout;
    logic [DW-1:0] v1, v2;
    int oe_bad;
    v1 = DW'($urandom);
    v2 = DW'($urandom);
    scan_ir(4'b0010, cap);
    scan_dr(DW, 64'(v1), dout, oe_bad);
    exp_a = v1;
    scan_dr(DW, 64'(v2), dout, oe_bad);
    checks++;
    if (dout[DW-1:0] !== v1) begin errors++; $display("[TB] FAIL b2b_capture: got %h expected %h", dout[DW-1:0], v1); end
    exp_a = v2;
    checks++;
    if (op_a !== exp_a) begin errors++; $display("[TB] FAIL b2b_load: got %h expected %h", op_a, exp_a); end
  endtask

  task automatic test_tlr();
    logic [3:0] cap;
    logic [63:0] din, dout, exp, left;
    logic t, o;
    int oe_bad, s0, j;
    scan_ir(4'b0011, cap);
    din = 64'($urandom);
    j = $urandom_range(1, 3);
    s0 = strobe_cnt;
    tck_step(1'b1);
    tck_step(1'b0);
    tck_cycle(1'b0, 1'b0, t, o);
    for (int k = 0; k < j; k++) tck_cycle(1'b0, din[k], t, o);
    tck_cycle(1'b1, din[j], t, o);
    for (int k = 0; k < 4; k++) tck_step(1'b1);
    left = model_left(DW, cap_val(4'b0011), din, j + 1);
    exp_b = left[DW-1:0];
    checks++;
    if (tap_state !== 4'hF) begin errors++; $display("[TB] FAIL tlr_state: got %h expected %h", tap_state, 4'hF); end
    checks++;
    if (op_a !== exp_a || op_b !== exp_b) begin errors++; $display("[TB] FAIL tlr_ops: got %h/%h expected %h/%h", op_a, op_b, exp_a, exp_b); end
    checks++;
    if (strobe_cnt - s0 != 1) begin errors++; $display("[TB] FAIL tlr_strobe: got %0d expected 1", strobe_cnt - s0); end
    tck_step(1'b0);
    din = {32'd0, $urandom};
    scan_dr(32, din, dout, oe_bad);
    exp = model_out(dr_len(IR_RESET_TB), cap_val(IR_RESET_TB), din, 32);
    checks++;
    if (dout !== exp) begin errors++; $display("[TB] FAIL tlr_ir_reset: got %h expected %h", dout, exp); end
  endtask

  task automatic test_random();
    logic [3:0] cap, op;
    logic [63:0] din, dout, exp, left;
    logic [63:0] capv;
    int oe_bad, s0, n, len, sexp;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 4))
        0: op = 4'b0010;
        1: op = 4'b0011;
        2: op = 4'b0100;
        3: op = 4'b1111;
        default: op = 4'($urandom_range(0, 15));
      endcase
      y_in = DW'($urandom);
      len  = dr_len(op);
      n    = len + $urandom_range(0, 3);
      din  = {$urandom, $urandom};
      scan_ir(op, cap);
      capv = cap_val(op);
      s0   = strobe_cnt;
      scan_dr(n, din, dout, oe_bad);
      exp  = model_out(len, capv, din, n);
      left = model_left(len, capv, din, n);
      sexp = 0;
      if (op == 4'b0010) begin exp_a = left[DW-1:0]; sexp = 1; end
      if (op == 4'b0011) begin exp_b = left[DW-1:0]; sexp = 1; end
      checks++;
      if (dout !== exp) begin errors++; $display("[TB] FAIL rand_tdo op=%b n=%0d: got %h expected %h", op, n, dout, exp); end
      checks++;
      if (op_a !== exp_a || op_b !== exp_b) begin errors++; $display("[TB] FAIL rand_ops op=%b: got %h/%h expected %h/%h", op, op_a, op_b, exp_a, exp_b); end
      checks++;
      if (strobe_cnt - s0 != sexp) begin errors++; $display("[TB] FAIL rand_strobe op=%b: got %0d expected %0d", op, strobe_cnt - s0, sexp); end
      checks++;
      if (oe_bad != 0) begin errors++; $display("[TB] FAIL rand_oe op=%b: got %0d bad expected 0", op, oe_bad); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] cap;
    logic [63:0] dout;
    logic t, o;
    int oe_bad;
    scan_ir(4'b0010, cap);
    scan_dr(DW, 64'($urandom | 1), dout, oe_bad);
    tck_step(1'b1);
    tck_step(1'b0);
    tck_cycle(1'b0, 1'b0, t, o);
    tck_cycle(1'b0, 1'b1, t, o);
    checks++;
    if (tap_state !== 4'h2 || tdo_oe !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_shift: got %h oe=%b expected 2 oe=1", tap_state, tdo_oe); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (op_a !== '0 || op_b !== '0) begin errors++; $display("[TB] FAIL async_rst_ops: got %h/%h expected 0/0", op_a, op_b); end
    checks++;
    if (tdo_oe !== 1'b0 || tap_state !== 4'hF) begin errors++; $display("[TB] FAIL async_rst_tap: got oe=%b state=%h expected oe=0 state=f", tdo_oe, tap_state); end
    wait_clk(3);
    rst_n = 1'b1;
    exp_a = '0;
    exp_b = '0;
    wait_clk(2);
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    $display("[TB] starting jtag_dp_ctrl bench");
    test_reset();
    test_idcode();
    test_ir_capture();
    test_operand_load();
    test_result();
    test_bypass();
    test_back_to_back();
    test_tlr();
    tck_step(1'b0);
    test_random();
    test_async_reset();
    test_idcode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
